// File: rtl/string_window_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : string_window_pkg
//  Purpose  : Types and constants shared by the string window and the hash
//             stages that consume its output.
//  Contents : sw_state_e    - window FSM state encoding (IDLE/FILL/RUN)
//             BYTES_CNT_DEF - default window length in bytes
//  Revision : 1.0 - initial release
// ============================================================================
package string_window_pkg;

  localparam int BYTES_CNT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/string_window.sv
`default_nettype none
// ============================================================================
//  Module   : string_window
//  Purpose  : Sliding byte window over a packetised byte stream. Once a
//             packet has supplied BYTES_CNT bytes, every further byte yields
//             a new window together with the packet offset of its newest
//             byte. Packets shorter than the window produce nothing.
//  Ports    : clk_i, rst_n_i          - clock, async active-low reset
//             byte_i/byte_valid_i/
//             sop_i/eop_i/byte_ready_o - input byte stream (valid/ready)
//             string_o/pos_o/last_o/
//             string_valid_o/
//             string_ready_i           - window output (valid/ready)
//  Revision : 1.0 - initial release
// ============================================================================
module string_window
  import string_window_pkg::*;
#(
  parameter int BYTES_CNT = BYTES_CNT_DEF,
  parameter int POS_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [7:0]                 byte_i,
  input  logic                       byte_valid_i,
  input  logic                       sop_i,
  input  logic                       eop_i,
  output logic                       byte_ready_o,
  output logic [BYTES_CNT-1:0][7:0]  string_o,
  output logic [POS_W-1:0]           pos_o,
  output logic                       last_o,
  output logic                       string_valid_o,
  input  logic                       string_ready_i
);

  localparam int               CNT_W    = $clog2(BYTES_CNT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_CNT);
  localparam logic [CNT_W-1:0] PRE_FULL = CNT_W'(BYTES_CNT - 1);

  sw_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          fill_q, fill_d;
  logic [POS_W-1:0]          pos_q, pos_d;
  logic [BYTES_CNT-1:0][7:0] win_q, win_d;

  logic                      valid_q, valid_d;
  logic [BYTES_CNT-1:0][7:0] str_q, str_d;
  logic [POS_W-1:0]          opos_q, opos_d;
  logic                      last_q, last_d;

  logic                      accept;
  logic                      load;

  // The output register can always take a new window when it is empty or
  // being drained this cycle, so the input never sees a bubble.
  assign byte_ready_o = !valid_q || string_ready_i;
  assign accept       = byte_valid_i && byte_ready_o;

  // Window / counters / FSM next state
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    pos_d   = pos_q;
    win_d   = win_q;
    load    = 1'b0;

    if (accept) begin
      if (sop_i) begin
        // A start of packet always restarts, whatever state we were in;
        // older bytes are cleared so they can never leak into a window.
        win_d              = '0;
        win_d[BYTES_CNT-1] = byte_i;
        fill_d             = CNT_W'(1);
        pos_d              = '0;
        state_d            = FILL;
        if (eop_i) begin
          fill_d  = '0;
          state_d = IDLE;
        end
      end else if (state_q != IDLE) begin
        win_d = {byte_i, win_q[BYTES_CNT-1:1]};
        pos_d = (pos_q == '1) ? pos_q : pos_q + POS_W'(1);
        if (state_q == RUN || fill_q == PRE_FULL) begin
          load    = 1'b1;
          fill_d  = FULL_CNT;
          state_d = RUN;
        end else begin
          fill_d  = fill_q + CNT_W'(1);
          state_d = FILL;
        end
        if (eop_i) begin
          fill_d  = '0;
          state_d = IDLE;
        end
      end
      // Bytes outside a packet (IDLE without sop) are dropped.
    end
  end

  // Output register next state
  always_comb begin
    valid_d = valid_q;
    str_d   = str_q;
    opos_d  = opos_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      str_d   = win_d;
      opos_d  = pos_d;
      last_d  = eop_i;
    end else if (string_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      fill_q  <= '0;
      pos_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      str_q   <= '0;
      opos_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pos_q   <= pos_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      str_q   <= str_d;
      opos_q  <= opos_d;
      last_q  <= last_d;
    end
  end

  assign string_o       = str_q;
  assign pos_o          = opos_q;
  assign last_o         = last_q;
  assign string_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_string_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_string_window
//  Purpose  : Self-checking bench for string_window with BYTES_CNT=4,
//             POS_W=16. Windows are predicted when bytes are driven and
//             compared in order when the DUT hands them downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_string_window;

  logic             clk;
  logic             rst_n;
  logic [7:0]       byte_i;
  logic             byte_valid_i;
  logic             sop_i;
  logic             eop_i;
  logic             byte_ready_o;
  logic [3:0][7:0]  string_o;
  logic [15:0]      pos_o;
  logic             last_o;
  logic             string_valid_o;
  logic             string_ready_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  b;
    logic        sop;
    logic        eop;
    logic        emit;
    logic [31:0] win;   // oldest byte first
    logic [15:0] pos;
    logic        last;
  } vec_t;

  typedef struct {
    logic [31:0] win;
    logic [15:0] pos;
    logic        last;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t got;

  string_window #(
    .BYTES_CNT (4),
    .POS_W     (16)
  ) u_dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .sop_i          (sop_i),
    .eop_i          (eop_i),
    .byte_ready_o   (byte_ready_o),
    .string_o       (string_o),
    .pos_o          (pos_o),
    .last_o         (last_o),
    .string_valid_o (string_valid_o),
    .string_ready_i (string_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] oldest_first(input logic [3:0][7:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

  function automatic vec_t mk(input logic [7:0] b, input logic sop, input logic eop,
                              input logic emit, input logic [31:0] win,
                              input logic [15:0] pos, input logic last);
    vec_t v;
    v.b = b; v.sop = sop; v.eop = eop; v.emit = emit;
    v.win = win; v.pos = pos; v.last = last;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] win, input logic [15:0] pos, input logic last);
    exp_t e;
    e.win = win; e.pos = pos; e.last = last;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic s, input logic e);
    logic acc;
    int   n;
    n = 0;
    byte_i = b; sop_i = s; eop_i = e; byte_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      acc = byte_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte=%h not accepted after %0d cycles", b, n);
        break;
      end
    end
    byte_valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  // Scoreboard: each downstream handshake pops the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && string_valid_o && string_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window actual=%h pos=%0d last=%0d required=none",
                 oldest_first(string_o), pos_o, last_o);
      end else begin
        got = sb.pop_front();
        if (oldest_first(string_o) !== got.win || pos_o !== got.pos || last_o !== got.last) begin
          errors++;
          $display("FAIL window actual=%h/pos%0d/last%0d required=%h/pos%0d/last%0d",
                   oldest_first(string_o), pos_o, last_o, got.win, got.pos, got.last);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; byte_i = '0; byte_valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    string_ready_i = 1'b1;

    // Reset state
    #23;
    chk("rst_valid", 64'(string_valid_o), 64'd0);
    chk("rst_string", 64'(string_o), 64'd0);
    chk("rst_pos", 64'(pos_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_ready", 64'(byte_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-throughput vectors
    tbl.push_back(mk(8'h41, 1, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h42, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h43, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h44, 0, 0, 1, 32'h41424344, 16'd3, 0));
    tbl.push_back(mk(8'h45, 0, 0, 1, 32'h42434445, 16'd4, 0));
    tbl.push_back(mk(8'h46, 0, 1, 1, 32'h43444546, 16'd5, 1));
    tbl.push_back(mk(8'h10, 1, 0, 0, 32'h0, 16'd0, 0));       // short packet
    tbl.push_back(mk(8'h11, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h12, 0, 1, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h30, 0, 0, 0, 32'h0, 16'd0, 0));       // no sop: dropped
    tbl.push_back(mk(8'h31, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h32, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h20, 1, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h21, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h22, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h23, 0, 1, 1, 32'h20212223, 16'd3, 1));
    tbl.push_back(mk(8'h50, 1, 0, 0, 32'h0, 16'd0, 0));       // restart mid-packet
    tbl.push_back(mk(8'h51, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h52, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h53, 0, 0, 1, 32'h50515253, 16'd3, 0));
    tbl.push_back(mk(8'h54, 0, 0, 1, 32'h51525354, 16'd4, 0));
    tbl.push_back(mk(8'h60, 1, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h61, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h62, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h63, 0, 0, 1, 32'h60616263, 16'd3, 0));
    tbl.push_back(mk(8'h64, 0, 1, 1, 32'h61626364, 16'd4, 1));
    tbl.push_back(mk(8'h70, 1, 1, 0, 32'h0, 16'd0, 0));       // one-byte packet
    tbl.push_back(mk(8'h71, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h72, 0, 0, 0, 32'h0, 16'd0, 0));
    tbl.push_back(mk(8'h73, 0, 0, 0, 32'h0, 16'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].emit) push(tbl[i].win, tbl[i].pos, tbl[i].last);
      send(tbl[i].b, tbl[i].sop, tbl[i].eop);
      chk($sformatf("valid_after_%0d", i), 64'(string_valid_o), 64'(tbl[i].emit));
    end

    // Downstream stall: window held, input blocked, nothing lost
    push(32'h41424344, 16'd3, 1'b0);
    send(8'h41, 1, 0);
    send(8'h42, 0, 0);
    send(8'h43, 0, 0);
    send(8'h44, 0, 0);
    string_ready_i = 1'b0;
    #1;
    chk("stall_ready", 64'(byte_ready_o), 64'd0);
    push(32'h42434445, 16'd4, 1'b0);
    byte_i = 8'h45; sop_i = 1'b0; eop_i = 1'b0; byte_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_ready_hold", 64'(byte_ready_o), 64'd0);
      chk("stall_string_hold", 64'(oldest_first(string_o)), 64'h41424344);
      chk("stall_pos_hold", 64'(pos_o), 64'd3);
    end
    string_ready_i = 1'b1;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    chk("stall_release_valid", 64'(string_valid_o), 64'd1);
    push(32'h43444546, 16'd5, 1'b1);
    send(8'h46, 0, 1);

    // Asynchronous reset while a window is pending
    send(8'h80, 1, 0);
    send(8'h81, 0, 0);
    send(8'h82, 0, 0);
    string_ready_i = 1'b0;
    send(8'h83, 0, 0);
    #2;
    chk("pre_rst_valid", 64'(string_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(string_valid_o), 64'd0);
    chk("async_rst_string", 64'(string_o), 64'd0);
    chk("async_rst_pos", 64'(pos_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    string_ready_i = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      send(8'h84 + 8'(k), 0, 0);
      chk("post_rst_nosop", 64'(string_valid_o), 64'd0);
    end
    push(32'h90919293, 16'd3, 1'b1);
    send(8'h90, 1, 0);
    send(8'h91, 0, 0);
    send(8'h92, 0, 0);
    send(8'h93, 0, 1);
    chk("post_rst_window", 64'(string_valid_o), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
